// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code definitions: checker FSM encoding, default width, decode helper.
package gray_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_t;

    // Prefix-XOR from the MSB down; narrower words just leave the upper bits zero.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational Gray to binary decode (XOR prefix from MSB).
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic [WIDTH-1:0] acc;

    always_comb begin
        acc = '0;
        acc[WIDTH-1] = gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            acc[i] = acc[i+1] ^ gray[i];
        end
        bin = acc;
    end

endmodule

// File: rtl/gray_step_checker.sv
// rtl/gray_step_checker.sv - checks a Gray counter stream for legal +1 steps; pulses, lock and counters.
module gray_step_checker
    import gray_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CNT_W      = 8,
    parameter int LOCK_STEPS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             change_p,
    output logic             wrap_p,
    output logic             step_err_p,
    output logic             err_sticky,
    output logic             locked,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] lap_count
);

    localparam int LC_W = (LOCK_STEPS > 1) ? $clog2(LOCK_STEPS) : 1;
    localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_STEPS - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] g_p;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_p;
    logic             q_vld;
    logic [LC_W-1:0]  lock_cnt;
    logic             changed;
    logic             legal;
    logic             illegal;
    logic             wrap;

    gray_to_bin #(.WIDTH(WIDTH)) u_dec_q (.gray(g_q), .bin(b_q));
    gray_to_bin #(.WIDTH(WIDTH)) u_dec_p (.gray(g_p), .bin(b_p));

    // INIT only seeds the reference, so no event is ever reported from it.
    assign changed = (state != INIT) && (g_q != g_p);
    assign legal   = changed && (b_q == b_p + WIDTH'(1));
    assign illegal = changed && !legal;
    assign wrap    = legal && (b_p == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_q     <= '0;
            g_p     <= '0;
            q_vld   <= 1'b0;
            bin_out <= '0;
        end else begin
            g_q     <= gray_in;
            g_p     <= g_q;
            q_vld   <= 1'b1;
            bin_out <= b_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            INIT:    if (q_vld) state_nx = ACQ;
            ACQ:     if (legal && lock_cnt == LOCK_LAST) state_nx = TRACK;
            TRACK:   if (illegal) state_nx = ACQ;
            default: state_nx = INIT;
        endcase
    end

    always_comb begin
        locked = (state == TRACK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_cnt <= '0;
        end else if (state != ACQ || illegal || (legal && lock_cnt == LOCK_LAST)) begin
            lock_cnt <= '0;
        end else if (legal) begin
            lock_cnt <= lock_cnt + LC_W'(1);
        end
    end

    // clr wins over a same-cycle increment, but the event pulses still fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            change_p   <= 1'b0;
            wrap_p     <= 1'b0;
            step_err_p <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            lap_count  <= '0;
        end else begin
            change_p   <= changed;
            wrap_p     <= wrap;
            step_err_p <= illegal;
            if (clr) begin
                err_sticky <= 1'b0;
                err_count  <= '0;
                lap_count  <= '0;
            end else begin
                if (illegal) err_sticky <= 1'b1;
                if (illegal && err_count != '1) err_count <= err_count + CNT_W'(1);
                if (wrap) lap_count <= lap_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gray_step_checker.sv
// tb/tb_gray_step_checker.sv - scoreboard bench for gray_step_checker with a sequence-level reference model.
module tb_gray_step_checker;

    localparam int LOCK_STEPS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] gray_in = 4'd0;
    logic [3:0] bin_out;
    logic       change_p, wrap_p, step_err_p, err_sticky, locked;
    logic [7:0] err_count, lap_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [3:0] bin;
        logic       chg;
        logic       wrap;
        logic       err;
        logic       sticky;
        logic       lck;
        logic [7:0] ec;
        logic [7:0] lc;
    } obs_t;

    typedef struct {
        int   due;
        obs_t v;
    } entry_t;

    entry_t sb[$];
    obs_t   act;

    bit have_ref, pend_vld, m_sticky;
    int ref_g, pend, run, m_ec, m_lc;

    int lap_seq[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    gray_step_checker #(.WIDTH(4), .CNT_W(8), .LOCK_STEPS(LOCK_STEPS)) dut (
        .clk(clk), .rst(rst), .clr(clr), .gray_in(gray_in),
        .bin_out(bin_out), .change_p(change_p), .wrap_p(wrap_p), .step_err_p(step_err_p),
        .err_sticky(err_sticky), .locked(locked), .err_count(err_count), .lap_count(lap_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign act = {bin_out, change_p, wrap_p, step_err_p, err_sticky, locked, err_count, lap_count};

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int bin_of(input int g);
        for (int i = 0; i < 16; i++) if (gray_of(i) == g) return i;
        return -1;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        pend_vld = 0; have_ref = 0; run = 0; m_ec = 0; m_lc = 0; m_sticky = 0; ref_g = 0;
    endtask

    // Evaluates sample p against the previous sample; c is the clr seen on the compare edge.
    task automatic model_step(input int p, input bit c);
        obs_t e;
        bit chg, wr, er;
        chg = 0; wr = 0; er = 0;
        if (have_ref && p != ref_g) begin
            chg = 1;
            if (bin_of(p) == (bin_of(ref_g) + 1) % 16) begin
                run++;
                wr = (bin_of(ref_g) == 15);
            end else begin
                er = 1;
                run = 0;
            end
        end
        have_ref = 1;
        ref_g = p;
        if (c) begin
            m_ec = 0; m_lc = 0; m_sticky = 0;
        end else begin
            if (er && m_ec < 255) m_ec++;
            if (er) m_sticky = 1;
            if (wr) m_lc = (m_lc + 1) % 256;
        end
        e = {4'(bin_of(p)), chg, wr, er, m_sticky, run >= LOCK_STEPS, 8'(m_ec), 8'(m_lc)};
        sb.push_back('{cyc + 1, e});
    endtask

    task automatic drive(input int v, input bit c);
        @(negedge clk);
        gray_in = 4'(v);
        clr = c;
        if (pend_vld) model_step(pend, c);
        pend = v;
        pend_vld = 1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
        clr = 1'b0;
        pend = int'(gray_in);
        pend_vld = 1;
    endtask

    task automatic async_reset(input string name);
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check(name, int'(act), 0);
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        entry_t t;
        forever begin
            @(posedge clk);
            #2;
            if (rst && sb.size() > 0 && sb[0].due <= cyc) begin
                t = sb.pop_front();
                checks++;
                if (t.due != cyc || act !== t.v) begin
                    errors++;
                    $display("FAIL scoreboard cyc=%0d due=%0d got bin=%0d chg=%b wrap=%b err=%b stk=%b lck=%b ec=%0d lc=%0d expected bin=%0d chg=%b wrap=%b err=%b stk=%b lck=%b ec=%0d lc=%0d",
                             cyc, t.due, act.bin, act.chg, act.wrap, act.err, act.sticky, act.lck, act.ec, act.lc,
                             t.v.bin, t.v.chg, t.v.wrap, t.v.err, t.v.sticky, t.v.lck, t.v.ec, t.v.lc);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int r, nx, n;
        #1 rst = 1'b0;
        #1 check("reset_state", int'(act), 0);
        model_reset();
        release_rst();

        // Full lap, then a two-bit skip, a backward step and a clr coinciding with an error.
        foreach (lap_seq[i]) drive(lap_seq[i], 0);
        drive(1, 0); drive(3, 0); drive(6, 0); drive(7, 0); drive(5, 0); drive(4, 0);
        drive(12, 0); drive(4, 0);
        drive(0, 0); drive(0, 1); drive(0, 0);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) drive((i % 2) ? 5 : 0, 0);
        drive(0, 1); drive(0, 0);

        // Lap counter wraps past all-ones.
        for (int l = 0; l < 257; l++)
            for (int b = 0; b < 16; b++) drive(gray_of((b + 1) % 16), 0);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 15);
            if (r < 10) nx = gray_of((bin_of(int'(gray_in)) + 1) % 16);
            else if (r < 12) nx = int'(gray_in);
            else nx = $urandom_range(0, 15);
            drive(nx, $urandom_range(0, 39) == 0);
        end

        // Mid-lap reset; first sample afterwards must only seed the reference.
        async_reset("async_reset_outputs");
        gray_in = 4'd13;
        release_rst();
        for (int b = 10; b < 16; b++) drive(gray_of(b), 0);
        drive(gray_of(0), 0); drive(gray_of(1), 0);

        // Constant input after reset: no events ever.
        async_reset("async_reset_hold");
        gray_in = 4'd6;
        release_rst();
        repeat (100) drive(6, 0);
        check("hold_bin_out", int'(bin_out), 4);
        check("hold_locked", int'(locked), 0);
        check("hold_err_count", int'(err_count), 0);
        check("hold_change_p", int'(change_p), 0);

        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
